multitrig: RTL and testbench
============================

# multitrig

Parametrised N-channel coincidence trigger for the WFD125 channel FPGA. It takes pedestal-subtracted samples from NCH prc1chan's and fires a single-cycle trigger when enough channels are over an individual threshold and their masked sum is over a sum threshold. Re-arming uses half-threshold hysteresis plus a programmable holdoff. It sits between the prc1chan outputs and the trigger/readout logic, clocked by ADCCLK.

## Interface
- NCH, 4: number of channels, 2..16
- ABITS, 12: threshold width
- HBITS, 8: holdoff counter width
- ADCCLK  in  1  ADC clock, common for all channels
- reset  in  1  asynchronous, active-high reset
- dpdata  in  16*NCH  channel i at [16*i+15:16*i], signed two's complement, ADC clocked
- chmask  in  NCH  1 = channel participates in count and sum
- ithr  in  ABITS  individual channel threshold, unsigned
- sthr  in  ABITS  sum threshold, unsigned
- mult  in  5  required number of over-threshold channels (0 treated as 1)
- holdoff  in  HBITS  dead clocks after re-arm condition before the next trigger
- inhibit  in  1  cumulative inhibit, asynchronous to nothing, ADCCLK domain
- exttrig  in  1  external trigger, asynchronous
- trig  out  1  trigger pulse, one ADCCLK wide
- tcnt  out  32  count of internal (coincidence) triggers

## Operation
- Stage P: register dpdata per channel.
- Stage C: register P into ch[i]. Register a masked sum S = Σ ch_p[i] over chmask. S is signed, 16+clog2(NCH) bits, and never overflows. Register the masked over-flags: ov[i] = chmask[i] & (ch_p[i] > signed{0,ithr}).
- Coincidence: hit = (popcount(ov) >= max(mult,1)) & (S > signed{0,sthr}).
- Release: rel = S <= signed{0,sthr[ABITS-1:1]}.
- State machine, registered on ADCCLK:
  - ARMED: hit -> FIRED, internal trigger pulse, tcnt+1.
  - FIRED: rel -> HOLD with counter = holdoff. If holdoff == 0, go straight to ARMED.
  - HOLD: decrement counter. At 1 -> ARMED. hit is ignored in HOLD.
- inhibit is registered once (inh). While inh = 1, the state is forced to ARMED, the counter is cleared, and no internal trigger fires. Going from inh 1 to 0 while hit is true fires on the first uninhibited cycle.
- trig = internal pulse OR external pulse, registered.
- tcnt is 32-bit and wraps 0xFFFFFFFF -> 0. External triggers and inhibited cycles are not counted.
- chmask = 0: S = 0 and popcount = 0, so no internal trigger. The state machine still tracks release.
- reset (async): all pipeline registers 0, state ARMED, counter 0, inh 0, trig 0, tcnt 0, synchronizer flops 0.

## Timing
- Data presented before ADCCLK edge n is captured in P at edge n, lands in C/S/ov at edge n+1, and produces trig high after edge n+2. Latency is 2 clocks from capture.
- trig is exactly 1 clock wide per event. Internal and external pulses in the same cycle give a single 1-clock pulse.
- Minimum spacing between internal triggers is one cycle in FIRED plus holdoff cycles in HOLD plus the re-hit cycle.
- Changes to ithr, sthr, mult, chmask or holdoff take effect on the next comparison. They are quasi-static and are not synchronised.

## Configuration
- MULTITRIG_EXT_EN defined:
  - exttrig goes through a 2-flop synchronizer and a rising-edge detector.
  - Each rising edge produces one trig pulse 3 clocks after the edge that first samples it high.
  - The external path ignores inhibit and the state machine.
- Not defined: exttrig is unused, and trig comes only from the coincidence path.

## Test plan
- NCH=4, mult=2, ithr=100, sthr=300, all channels masked in, holdoff=0. ch0=ch1=200 and others 0, held 10 clocks, then all 0 -> one trig, 2 clocks after capture, tcnt=1. Repeat once -> tcnt=2.
- Hysteresis: sthr=300, ch0=ch1=160 (S=320) -> trig. Drop to S=200 with both still >ithr -> no new trig (200 > 150). Drop to S=140 (<=150), then back to 320 -> second trig.
- Holdoff=5: trigger, release, re-hit continuously -> next trig exactly 7 clocks after the first (FIRED 1, HOLD 5, re-hit 1).
- Mask/multiplicity: chmask=0b1110, ch0=ch1=500 -> no trig. chmask=0b1111 -> trig. mult=0 with a single channel at 500, sthr=300 -> trig.
- Inhibit: inhibit=1 with a hit pattern for 20 clocks -> trig=0, tcnt unchanged. Drop inhibit -> trig 2 clocks later. Assert reset mid-HOLD -> trig=0, tcnt=0, state ARMED.
- With MULTITRIG_EXT_EN: a 3 ns exttrig pulse aligned to an edge, with inhibit=1 -> exactly one trig pulse, tcnt unchanged.

Source files
------------

// File: rtl/multitrig_if.sv
// multitrig_if: channel data, trigger configuration and trigger outputs for multitrig.
// Latency: none, this file only groups the wires.
// Backpressure: none, all signals are free-running in the ADCCLK domain.
interface multitrig_if #(
    parameter int NCH   = 4,
    parameter int ABITS = 12,
    parameter int HBITS = 8
);
    logic [16*NCH-1:0] dpdata;
    logic [NCH-1:0]    chmask;
    logic [ABITS-1:0]  ithr;
    logic [ABITS-1:0]  sthr;
    logic [4:0]        mult;
    logic [HBITS-1:0]  holdoff;
    logic              inhibit;
    logic              exttrig;
    logic              trig;
    logic [31:0]       tcnt;

    // Source side: the prc1chan outputs and the register block.
    modport master (
        output dpdata, chmask, ithr, sthr, mult, holdoff, inhibit, exttrig,
        input  trig, tcnt
    );

    // Trigger side.
    modport slave (
        input  dpdata, chmask, ithr, sthr, mult, holdoff, inhibit, exttrig,
        output trig, tcnt
    );
endinterface

// File: rtl/multitrig.sv
// multitrig: N-channel coincidence trigger with half-threshold re-arm hysteresis and holdoff.
// Latency: trig is high after the second ADCCLK edge following sample capture.
// Backpressure: none; inhibit suppresses internal triggers. Optional MULTITRIG_EXT_EN adds exttrig.
module multitrig #(
    parameter int NCH   = 4,
    parameter int ABITS = 12,
    parameter int HBITS = 8
) (
    input  logic        ADCCLK,
    input  logic        reset,
    multitrig_if.slave  bus
);
    // Sum width grows by clog2(NCH) so that the masked sum can never overflow.
    localparam int SW = 16 + $clog2(NCH);

    typedef enum logic [1:0] {ST_ARMED, ST_FIRED, ST_HOLD} state_t;

    logic signed [15:0]    r_p [NCH];
    logic signed [SW-1:0]  r_sum;
    logic [NCH-1:0]        r_ov;
    logic                  r_inh;
    state_t                r_state;
    state_t                w_nstate;
    logic [HBITS-1:0]      r_cnt;
    logic [HBITS-1:0]      w_ncnt;
    logic                  r_trig;
    logic [31:0]           r_tcnt;

    logic signed [SW-1:0]  w_sum;
    logic [NCH-1:0]        w_ov;
    logic signed [16:0]    w_ithr_x;
    logic signed [SW-1:0]  w_sthr_x;
    logic signed [SW-1:0]  w_shalf_x;
    logic [4:0]            w_pop;
    logic [4:0]            w_mreq;
    logic                  w_hit;
    logic                  w_rel;
    logic                  w_fire;
    logic                  w_ext;

    // Thresholds are unsigned; zero-extend them so signed compares against samples are exact.
    assign w_ithr_x  = {{(17-ABITS){1'b0}}, bus.ithr};
    assign w_sthr_x  = {{(SW-ABITS){1'b0}}, bus.sthr};
    assign w_shalf_x = {{(SW-ABITS+1){1'b0}}, bus.sthr[ABITS-1:1]};

    // Stage P: capture every channel sample.
    always_ff @(posedge ADCCLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) r_p[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) r_p[i] <= bus.dpdata[16*i +: 16];
        end
    end

    // Masked sum and masked over-threshold flags taken from stage P.
    always_comb begin
        logic signed [16:0] v_ch;
        w_sum = '0;
        w_ov  = '0;
        v_ch  = '0;
        for (int i = 0; i < NCH; i++) begin
            v_ch = {r_p[i][15], r_p[i]};
            if (bus.chmask[i]) begin
                w_sum   = w_sum + $signed({{(SW-16){r_p[i][15]}}, r_p[i]});
                w_ov[i] = (v_ch > w_ithr_x);
            end
        end
    end

    // Stage C keeps only the sum and flags; nothing downstream needs per-channel copies.
    always_ff @(posedge ADCCLK or posedge reset) begin
        if (reset) begin
            r_sum <= '0;
            r_ov  <= '0;
        end else begin
            r_sum <= w_sum;
            r_ov  <= w_ov;
        end
    end

    // Coincidence and release decisions from stage C against the live configuration.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NCH; i++) w_pop = w_pop + {4'b0, r_ov[i]};
        w_mreq = (bus.mult == 5'd0) ? 5'd1 : bus.mult;
        w_hit  = (w_pop >= w_mreq) && (r_sum > w_sthr_x);
        w_rel  = (r_sum <= w_shalf_x);
    end

    // Trigger state machine: next state, holdoff counter and internal fire pulse.
    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_fire   = 1'b0;
        if (r_inh) begin
            w_nstate = ST_ARMED;
            w_ncnt   = '0;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (w_hit) begin
                        w_nstate = ST_FIRED;
                        w_fire   = 1'b1;
                    end
                end
                ST_FIRED: begin
                    if (w_rel) begin
                        if (bus.holdoff == '0) begin
                            w_nstate = ST_ARMED;
                        end else begin
                            w_nstate = ST_HOLD;
                            w_ncnt   = bus.holdoff;
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_cnt <= HBITS'(1)) begin
                        w_nstate = ST_ARMED;
                        w_ncnt   = '0;
                    end else begin
                        w_ncnt = r_cnt - HBITS'(1);
                    end
                end
                default: begin
                    w_nstate = ST_ARMED;
                    w_ncnt   = '0;
                end
            endcase
        end
    end

    // State register, inhibit flop, trigger output and internal trigger counter.
    always_ff @(posedge ADCCLK or posedge reset) begin
        if (reset) begin
            r_state <= ST_ARMED;
            r_cnt   <= '0;
            r_inh   <= 1'b0;
            r_trig  <= 1'b0;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            r_inh   <= bus.inhibit;
            r_trig  <= w_fire | w_ext;
            r_tcnt  <= r_tcnt + {31'b0, w_fire};
        end
    end

`ifdef MULTITRIG_EXT_EN
    logic r_es1, r_es2, r_es3, r_ext;

    // External trigger: two-flop synchronizer, rising-edge detect, one alignment flop.
    always_ff @(posedge ADCCLK or posedge reset) begin
        if (reset) begin
            r_es1 <= 1'b0;
            r_es2 <= 1'b0;
            r_es3 <= 1'b0;
            r_ext <= 1'b0;
        end else begin
            r_es1 <= bus.exttrig;
            r_es2 <= r_es1;
            r_es3 <= r_es2;
            r_ext <= r_es2 & ~r_es3;
        end
    end
    assign w_ext = r_ext;
`else
    logic w_unused_ext;
    assign w_unused_ext = bus.exttrig;
    assign w_ext        = 1'b0;
`endif

    assign bus.trig = r_trig;
    assign bus.tcnt = r_tcnt;
endmodule

// File: tb/tb_multitrig.sv
// tb_multitrig: directed test-plan steps followed by a randomized run, all checked against
// a timeline reference model (trigger times, release times, re-arm times) kept in the bench.
module tb_multitrig;
    localparam int MAXC = 4096;
`ifdef MULTITRIG_EXT_EN
    localparam bit EXT_ON = 1'b1;
`else
    localparam bit EXT_ON = 1'b0;
`endif

    logic ADCCLK = 1'b0;
    logic reset;
    always #5 ADCCLK = ~ADCCLK;

    multitrig_if #(.NCH(4), .ABITS(12), .HBITS(8)) bus ();
    multitrig #(.NCH(4), .ABITS(12), .HBITS(8)) dut (.ADCCLK(ADCCLK), .reset(reset), .bus(bus));

    // Input history, indexed by the clock edge that samples the value.
    logic [63:0] h_dp   [MAXC];
    logic [3:0]  h_mask [MAXC];
    int          h_ithr [MAXC];
    int          h_sthr [MAXC];
    int          h_mult [MAXC];
    int          h_hold [MAXC];
    bit          h_inh  [MAXC];
    bit          h_ext  [MAXC];

    int          cyc, rb, armed_at, total, bad, base;
    bit          waiting;
    logic        exp_trig;
    logic [31:0] exp_tcnt;
    int          rises[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int rise_at(input int k);
        return (rises.size() > k) ? rises[k] : -1000;
    endfunction

    // One clock: record inputs, let the edge happen, advance the model, compare.
    task automatic tick();
        int s, c, req, v, e;
        bit inh, hit, rel, fire, extp;
        logic [15:0] w;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget observed=%0d expected<%0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        h_dp[cyc]   = bus.dpdata;
        h_mask[cyc] = bus.chmask;
        h_ithr[cyc] = int'(bus.ithr);
        h_sthr[cyc] = int'(bus.sthr);
        h_mult[cyc] = int'(bus.mult);
        h_hold[cyc] = int'(bus.holdoff);
        h_inh[cyc]  = bus.inhibit;
        h_ext[cyc]  = bus.exttrig;
        @(posedge ADCCLK);
        e = cyc;
        s = 0;
        c = 0;
        if (e - 2 >= rb) begin
            for (int i = 0; i < 4; i++) begin
                w = h_dp[e-2][16*i +: 16];
                v = $signed(w);
                if (h_mask[e-1][i]) begin
                    s += v;
                    if (v > h_ithr[e-1]) c++;
                end
            end
        end
        req  = (h_mult[e] == 0) ? 1 : h_mult[e];
        hit  = (c >= req) && (s > h_sthr[e]);
        rel  = (s <= h_sthr[e] / 2);
        inh  = (e - 1 >= rb) ? h_inh[e-1] : 1'b0;
        fire = 1'b0;
        if (inh) begin
            waiting  = 1'b0;
            armed_at = e + 1;
        end else if (waiting) begin
            if (rel) begin
                waiting  = 1'b0;
                armed_at = e + h_hold[e] + 1;
            end
        end else if (e >= armed_at && hit) begin
            fire    = 1'b1;
            waiting = 1'b1;
        end
        extp = EXT_ON && (e - 3 >= rb) && h_ext[e-3] && !((e - 4 >= rb) && h_ext[e-4]);
        exp_trig = fire | extp;
        if (fire) exp_tcnt++;
        cyc++;
        #1;
        check("trig", bus.trig, exp_trig);
        check("tcnt", bus.tcnt, exp_tcnt);
        if (bus.trig === 1'b1) rises.push_back(e);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic setch(input int a, input int b, input int c, input int d);
        bus.dpdata = {16'(d), 16'(c), 16'(b), 16'(a)};
    endtask

    // A 3 ns exttrig pulse straddling one rising edge.
    task automatic ext_pulse_tick();
        @(negedge ADCCLK);
        #3;
        bus.exttrig = 1'b1;
        tick();
        bus.exttrig = 1'b0;
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(700)) - 300;
    endfunction

    initial begin
        total = 0; bad = 0;
        reset = 1'b1;
        setch(0, 0, 0, 0);
        bus.chmask = 4'hF; bus.ithr = 12'd100; bus.sthr = 12'd300; bus.mult = 5'd2;
        bus.holdoff = 8'd0; bus.inhibit = 1'b0; bus.exttrig = 1'b0;
        #2;
        check("reset_trig", bus.trig, 0);
        check("reset_tcnt", bus.tcnt, 0);
        #10;
        reset = 1'b0;
        cyc = 0; rb = 0; armed_at = 0; waiting = 1'b0; exp_tcnt = 0;

        // Basic coincidence, twice.
        for (int r = 0; r < 2; r++) begin
            rises.delete(); base = cyc;
            setch(200, 200, 0, 0); run(10);
            setch(0, 0, 0, 0);     run(10);
            check("basic_count", rises.size(), 1);
            check("basic_latency", rise_at(0) - base, 2);
            check("basic_tcnt", bus.tcnt, r + 1);
        end

        // Hysteresis around sthr/2.
        bus.ithr = 12'd90; rises.delete();
        setch(160, 160, 0, 0); run(6);
        setch(100, 100, 0, 0); run(8);
        setch(160, 160, 0, 0); run(8);
        check("hyst_no_rearm", rises.size(), 1);
        setch(70, 70, 0, 0);   run(6);
        setch(160, 160, 0, 0); run(6);
        setch(0, 0, 0, 0);     run(6);
        check("hyst_rearm", rises.size(), 2);

        // Holdoff spacing: FIRED 1 + HOLD 5 + re-hit 1.
        bus.ithr = 12'd100; bus.holdoff = 8'd5; rises.delete(); base = cyc;
        setch(160, 160, 0, 0); run(1);
        setch(0, 0, 0, 0);     run(1);
        setch(160, 160, 0, 0); run(12);
        setch(0, 0, 0, 0);     run(10);
        check("holdoff_count", rises.size(), 2);
        check("holdoff_spacing", rise_at(1) - rise_at(0), 7);
        bus.holdoff = 8'd0;

        // Mask and multiplicity.
        rises.delete();
        bus.chmask = 4'b1110; setch(500, 500, 0, 0); run(6);
        check("mask_blocks", rises.size(), 0);
        bus.chmask = 4'b1111; run(6);
        check("mask_all", rises.size(), 1);
        setch(0, 0, 0, 0); run(6);
        bus.mult = 5'd0; rises.delete();
        setch(500, 0, 0, 0); run(6);
        setch(0, 0, 0, 0);   run(6);
        check("mult_zero", rises.size(), 1);
        bus.mult = 5'd2;

        // Inhibit, external pulse under inhibit, then release of inhibit.
        bus.inhibit = 1'b1; rises.delete(); base = exp_tcnt;
        setch(500, 500, 0, 0); run(20);
        check("inhibit_quiet", rises.size(), 0);
        ext_pulse_tick(); run(6);
        check("ext_under_inhibit", rises.size(), EXT_ON ? 1 : 0);
        check("inhibit_tcnt", bus.tcnt, 32'(base));
        rises.delete(); bus.inhibit = 1'b0; base = cyc;
        run(4);
        check("uninhibit_count", rises.size(), 1);
        check("uninhibit_latency", rise_at(0) - base, 1);
        setch(0, 0, 0, 0); run(6);

        // Reset in the middle of a long holdoff.
        bus.holdoff = 8'd200;
        setch(500, 500, 0, 0); run(1);
        setch(0, 0, 0, 0);     run(6);
        #1 reset = 1'b1;
        #1;
        check("midhold_reset_trig", bus.trig, 0);
        check("midhold_reset_tcnt", bus.tcnt, 0);
        @(negedge ADCCLK); @(negedge ADCCLK);
        reset = 1'b0;
        rb = cyc; armed_at = cyc; waiting = 1'b0; exp_tcnt = 0;
        rises.delete(); base = cyc;
        setch(500, 500, 0, 0); run(5);
        setch(0, 0, 0, 0);     run(4);
        check("post_reset_armed", rise_at(0) - base, 2);
        check("post_reset_tcnt", bus.tcnt, 1);

        // Randomized traffic with live reconfiguration.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(3) == 0) setch(rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample());
            if ($urandom_range(15) == 0) begin
                bus.chmask  = 4'($urandom);
                bus.ithr    = 12'($urandom_range(250));
                bus.sthr    = 12'($urandom_range(800));
                bus.mult    = 5'($urandom_range(5));
                bus.holdoff = 8'($urandom_range(6));
            end
            bus.inhibit = ($urandom_range(11) == 0);
            if ($urandom_range(5) == 0) bus.exttrig = ~bus.exttrig;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
